tlk2711_tx_pattern: RTL and testbench

TLK2711_TX_PATTERN -- requirements
Module: tlk2711_tx_pattern

---
 rtl/tlk2711_tx_pattern.sv | 193 +++++++++++++++++++
 tb/tb_tlk2711_tx_pattern.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/tlk2711_tx_pattern.sv
// TLK2711 transmit test-pattern generator: framed sequences of SOF, header, payload,
// checksum and EOF words separated by idle fill, one word per clock.
module tlk2711_tx_pattern (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic [15:0] i_frame_len,
    input  logic [23:0] i_frame_num,
    input  logic [7:0]  i_gap,
    input  logic [15:0] i_seed,
    output logic        o_2711_tkmsb,
    output logic        o_2711_tklsb,
    output logic [15:0] o_2711_txd,
    output logic        o_busy,
    output logic        o_done,
    output logic [23:0] o_frame_cnt
);

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_SOF  = 4'd1,
        ST_HDR0 = 4'd2,
        ST_HDR1 = 4'd3,
        ST_LEN  = 4'd4,
        ST_DATA = 4'd5,
        ST_CHK  = 4'd6,
        ST_EOF  = 4'd7,
        ST_GAP  = 4'd8
    } state_t;

    localparam logic [15:0] W_IDLE = 16'hBCC5;
    localparam logic [15:0] W_SOF  = 16'hFB50;
    localparam logic [15:0] W_EOF  = 16'hFDFE;

    state_t      state_r;
    state_t      state_next_s;
    logic        stop_pend_r;
    logic        stop_now_s;
    logic        last_frame_s;
    logic [15:0] len_r;
    logic [23:0] num_r;
    logic [7:0]  gap_r;
    logic [15:0] seed_r;
    logic [23:0] frame_idx_r;
    logic [15:0] cnt_r;
    logic [15:0] pay_r;
    logic [15:0] sum_r;
    logic [15:0] word_s;
    logic [1:0]  k_s;

    // Next-state decision; a stop seen in the deciding cycle counts as pending.
    always_comb begin
        state_next_s = state_r;
        stop_now_s   = stop_pend_r | i_stop;
        last_frame_s = (num_r != 24'd0) && ((frame_idx_r + 24'd1) == num_r);
        case (state_r)
            ST_IDLE: begin
                if (i_start && !i_stop) begin
                    state_next_s = ST_SOF;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SOF:  state_next_s = ST_HDR0;
            ST_HDR0: state_next_s = ST_HDR1;
            ST_HDR1: state_next_s = ST_LEN;
            ST_LEN: begin
                if (len_r == 16'd0) begin
                    state_next_s = ST_CHK;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_r == len_r) begin
                    state_next_s = ST_CHK;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_CHK:  state_next_s = ST_EOF;
            ST_EOF: begin
                if (stop_now_s || last_frame_s) begin
                    state_next_s = ST_IDLE;
                end else if (gap_r == 8'd0) begin
                    state_next_s = ST_SOF;
                end else begin
                    state_next_s = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_r != {8'd0, gap_r}) begin
                    state_next_s = ST_GAP;
                end else if (stop_now_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_SOF;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Word and K flags for the state about to be entered, so outputs can be registered.
    always_comb begin
        word_s = W_IDLE;
        k_s    = 2'b10;
        case (state_next_s)
            ST_IDLE: begin word_s = W_IDLE;                    k_s = 2'b10; end
            ST_SOF:  begin word_s = W_SOF;                     k_s = 2'b10; end
            ST_HDR0: begin word_s = frame_idx_r[23:8];         k_s = 2'b00; end
            ST_HDR1: begin word_s = {frame_idx_r[7:0], 8'h00}; k_s = 2'b00; end
            ST_LEN:  begin word_s = len_r;                     k_s = 2'b00; end
            ST_DATA: begin word_s = pay_r;                     k_s = 2'b00; end
            ST_CHK:  begin word_s = sum_r;                     k_s = 2'b00; end
            ST_EOF:  begin word_s = W_EOF;                     k_s = 2'b10; end
            ST_GAP:  begin word_s = W_IDLE;                    k_s = 2'b10; end
            default: begin word_s = W_IDLE;                    k_s = 2'b10; end
        endcase
    end

    // State, registered outputs and per-frame bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            o_2711_txd   <= W_IDLE;
            o_2711_tkmsb <= 1'b1;
            o_2711_tklsb <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_frame_cnt  <= 24'd0;
            stop_pend_r  <= 1'b0;
            len_r        <= 16'd0;
            num_r        <= 24'd0;
            gap_r        <= 8'd0;
            seed_r       <= 16'd0;
            frame_idx_r  <= 24'd0;
            cnt_r        <= 16'd0;
            pay_r        <= 16'd0;
            sum_r        <= 16'd0;
        end else begin
            state_r      <= state_next_s;
            o_2711_txd   <= word_s;
            o_2711_tkmsb <= k_s[1];
            o_2711_tklsb <= k_s[0];
            o_busy       <= (state_next_s != ST_IDLE);
            o_done       <= (state_r != ST_IDLE) && (state_next_s == ST_IDLE);
            if (state_next_s == ST_IDLE) begin
                stop_pend_r <= 1'b0;
            end else if (i_stop) begin
                stop_pend_r <= 1'b1;
            end else begin
                stop_pend_r <= stop_pend_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (state_next_s == ST_SOF) begin
                        len_r       <= i_frame_len;
                        num_r       <= i_frame_num;
                        gap_r       <= i_gap;
                        seed_r      <= i_seed;
                        frame_idx_r <= 24'd0;
                        o_frame_cnt <= 24'd0;
                    end
                end
                ST_SOF: begin
                    pay_r <= seed_r;
                    sum_r <= 16'd0;
                    cnt_r <= 16'd0;
                end
                // cnt_r counts payload words already emitted.
                ST_LEN, ST_DATA: begin
                    if (state_next_s == ST_DATA) begin
                        pay_r <= pay_r + 16'd1;
                        sum_r <= sum_r + pay_r;
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_CHK: o_frame_cnt <= o_frame_cnt + 24'd1;
                ST_EOF: begin
                    if (state_next_s != ST_IDLE) begin
                        frame_idx_r <= frame_idx_r + 24'd1;
                        cnt_r       <= 16'd1;
                    end
                end
                ST_GAP: cnt_r <= cnt_r + 16'd1;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule

// File: tb/tb_tlk2711_tx_pattern.sv
// Scoreboard bench for tlk2711_tx_pattern: a reference model queues the expected
// word stream per sequence and every clock's output is popped and compared.
module tb_tlk2711_tx_pattern;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_stop = 1'b0;
    logic [15:0] i_frame_len = 16'd0;
    logic [23:0] i_frame_num = 24'd0;
    logic [7:0]  i_gap = 8'd0;
    logic [15:0] i_seed = 16'd0;
    logic        o_2711_tkmsb;
    logic        o_2711_tklsb;
    logic [15:0] o_2711_txd;
    logic        o_busy;
    logic        o_done;
    logic [23:0] o_frame_cnt;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [19:0] val;
        logic [23:0] cnt;
    } exp_t;
    exp_t sb_q[$];

    tlk2711_tx_pattern dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_stop       (i_stop),
        .i_frame_len  (i_frame_len),
        .i_frame_num  (i_frame_num),
        .i_gap        (i_gap),
        .i_seed       (i_seed),
        .o_2711_tkmsb (o_2711_tkmsb),
        .o_2711_tklsb (o_2711_tklsb),
        .o_2711_txd   (o_2711_txd),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_frame_cnt  (o_frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // {busy, done, tkmsb, tklsb, txd}
    function automatic logic [19:0] obs_word();
        return {o_busy, o_done, o_2711_tkmsb, o_2711_tklsb, o_2711_txd};
    endfunction

    task automatic push(input logic [15:0] w, input logic [1:0] k, input logic b,
                        input logic d, input logic [23:0] c);
        exp_t e;
        e.val = {b, d, k, w};
        e.cnt = c;
        sb_q.push_back(e);
    endtask

    task automatic check_idle(input string tag, input logic [23:0] c);
        check({tag, "_word"}, {12'd0, obs_word()}, {12'd0, 2'b00, 2'b10, 16'hBCC5});
        check({tag, "_cnt"}, {8'd0, o_frame_cnt}, {8'd0, c});
    endtask

    // Model the stream, then start the DUT and compare it cycle by cycle.
    task automatic run_seq(input logic [15:0] len, input logic [23:0] num, input int nfr,
                           input logic [7:0] gap, input logic [15:0] seed, input bit trail,
                           input int stop_at, input int start_at, input int rst_at);
        logic [23:0] c;
        logic [23:0] idx;
        logic [15:0] w;
        logic [15:0] sum;
        int          n;
        exp_t        e;
        c = 24'd0;
        for (int f = 0; f < nfr; f++) begin
            idx = 24'(f);
            push(16'hFB50, 2'b10, 1'b1, 1'b0, c);
            push(idx[23:8], 2'b00, 1'b1, 1'b0, c);
            push({idx[7:0], 8'h00}, 2'b00, 1'b1, 1'b0, c);
            push(len, 2'b00, 1'b1, 1'b0, c);
            sum = 16'd0;
            for (int k = 0; k < int'(len); k++) begin
                w   = seed + 16'(k);
                sum = sum + w;
                push(w, 2'b00, 1'b1, 1'b0, c);
            end
            push(sum, 2'b00, 1'b1, 1'b0, c);
            c = c + 24'd1;
            push(16'hFDFE, 2'b10, 1'b1, 1'b0, c);
            if ((f < nfr - 1) || trail) begin
                for (int g = 0; g < int'(gap); g++) push(16'hBCC5, 2'b10, 1'b1, 1'b0, c);
            end
        end
        push(16'hBCC5, 2'b10, 1'b0, 1'b1, c);
        push(16'hBCC5, 2'b10, 1'b0, 1'b0, c);
        if (rst_at > 0) begin
            while (sb_q.size() > rst_at) void'(sb_q.pop_back());
            push(16'hBCC5, 2'b10, 1'b0, 1'b0, 24'd0);
            push(16'hBCC5, 2'b10, 1'b0, 1'b0, 24'd0);
        end
        i_frame_len = len;
        i_frame_num = num;
        i_gap       = gap;
        i_seed      = seed;
        i_start     = 1'b1;
        n = sb_q.size();
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            i_start = 1'b0;
            i_stop  = 1'b0;
            rst     = 1'b0;
            if (i == 1) begin
                // Parameters must be held from the accepted start, not followed live.
                i_frame_len = 16'($urandom_range(1, 200));
                i_frame_num = 24'($urandom);
                i_gap       = 8'($urandom);
                i_seed      = 16'($urandom);
            end
            e = sb_q.pop_front();
            check("word", {12'd0, obs_word()}, {12'd0, e.val});
            check("frame_cnt", {8'd0, o_frame_cnt}, {8'd0, e.cnt});
            rst     = (i == rst_at);
            i_stop  = (i == stop_at);
            i_start = (i == start_at);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset", 24'd0);
        rst = 1'b0;

        // start and stop together in IDLE: nothing starts
        i_frame_len = 16'd2; i_frame_num = 24'd1; i_gap = 8'd0;
        i_start = 1'b1; i_stop = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0; i_stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_idle("start_stop", 24'd0);
            @(posedge clk);
            #1;
        end

        // single frame
        run_seq(16'd3, 24'd1, 1, 8'd2, 16'h0010, 1'b0, 0, 0, 0);
        // multi-frame with a start pulse while busy that must be ignored
        run_seq(16'd2, 24'd3, 3, 8'd1, 16'h1234, 1'b0, 0, 5, 0);
        // zero-length frames, back to back
        run_seq(16'd0, 24'd2, 2, 8'd0, 16'hABCD, 1'b0, 0, 0, 0);
        // continuous mode, stop during DATA of frame 5 (frame period 12)
        run_seq(16'd4, 24'd0, 5, 8'd2, 16'h0100, 1'b0, 54, 0, 0);
        // checksum wrap
        run_seq(16'd4, 24'd1, 1, 8'd0, 16'hFFFE, 1'b0, 0, 0, 0);
        // stop during the gap: the gap is finished, then IDLE with done
        run_seq(16'd1, 24'd0, 1, 8'd4, 16'h7777, 1'b1, 9, 0, 0);
        // reset in the middle of DATA
        run_seq(16'd8, 24'd1, 1, 8'd0, 16'h0005, 1'b0, 0, 0, 7);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
